// File: rtl/gemm_seq_ctrl.sv
// ============================================================================
// Module   : gemm_seq_ctrl
// Brief    : Job sequencer for the matrix-multiply path: load A/B rows, feed the
//            core, drain results, stream them out. Optional macro
//            GEMM_SEQ_PERF_CNT_EN enables the per-job cycle counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gemm_seq_ctrl #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 32,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] gbuff_a,
    input  logic [DATA_W-1:0] gbuff_b,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  n,
    input  logic [DIM_W-1:0]  k,
    output logic [DIM_W-1:0]  cfg_n,
    output logic              tpu_in_valid,
    input  logic              tpu_in_ready,
    output logic [DATA_W-1:0] tpu_a,
    output logic [DATA_W-1:0] tpu_b,
    input  logic              tpu_out_valid,
    output logic              tpu_out_ready,
    input  logic [DATA_W-1:0] tpu_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] gbuff_out,
    output logic              done,
    output logic              err,
    output logic [31:0]       cycle_cnt
);

    localparam int              C_CNT_W = $clog2(DEPTH) + 1;
    localparam int              C_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DIM_W-1:0] C_DEPTH = DIM_W'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_CNT_W-1:0] r_k_last;
    logic [C_CNT_W-1:0] r_m_last;
    logic               r_err;
    logic [DIM_W-1:0]   r_cfg_n;

    logic [DATA_W-1:0]  r_a_mem [DEPTH];
    logic [DATA_W-1:0]  r_b_mem [DEPTH];
    logic [DATA_W-1:0]  r_o_mem [DEPTH];

    logic [C_IDX_W-1:0] w_idx;
    logic               w_illegal;
    logic               w_ab_we;
    logic               w_o_we;

    assign w_idx     = r_cnt[C_IDX_W-1:0];
    assign w_illegal = (k == '0) || (m == '0) || (k > C_DEPTH) || (m > C_DEPTH);
    assign w_ab_we   = in_valid && ((r_state == S_IDLE && !w_illegal) || r_state == S_LOAD);
    assign w_o_we    = tpu_out_valid && (r_state == S_DRAIN);

    assign in_ready      = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign tpu_in_valid  = (r_state == S_FEED);
    assign tpu_out_ready = (r_state == S_DRAIN);
    assign out_valid     = (r_state == S_OUT);
    assign done          = (r_state == S_DONE);
    assign err           = (r_state == S_DONE) && r_err;
    assign cfg_n         = r_cfg_n;
    assign tpu_a         = tpu_in_valid ? r_a_mem[w_idx] : '0;
    assign tpu_b         = tpu_in_valid ? r_b_mem[w_idx] : '0;
    assign gbuff_out     = out_valid    ? r_o_mem[w_idx] : '0;

    // Row buffers carry no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (w_ab_we) begin
            r_a_mem[w_idx] <= gbuff_a;
            r_b_mem[w_idx] <= gbuff_b;
        end
        if (w_o_we) begin
            r_o_mem[w_idx] <= tpu_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_k_last <= '0;
            r_m_last <= '0;
            r_err    <= 1'b0;
            r_cfg_n  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cfg_n  <= n;
                        r_k_last <= C_CNT_W'(k - DIM_W'(1));
                        r_m_last <= C_CNT_W'(m - DIM_W'(1));
                        r_cnt    <= '0;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else if (k == DIM_W'(1)) begin
                            r_state <= S_FEED;
                        end else begin
                            r_cnt   <= C_CNT_W'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_cnt == r_k_last) begin
                            r_cnt   <= '0;
                            r_state <= S_FEED;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                S_FEED: begin
                    if (tpu_in_ready) begin
                        if (r_cnt == r_k_last) begin
                            r_cnt   <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (tpu_out_valid) begin
                        if (r_cnt == r_m_last) begin
                            r_cnt   <= '0;
                            r_state <= S_OUT;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_cnt <= '0;
                        if (r_cnt == r_m_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GEMM_SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;

    // The accepting IDLE cycle counts as the job's first cycle, so a
    // finished job reports its full first-beat-to-done latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (in_valid) begin
                r_cycle_cnt <= 32'd1;
            end
        end else if (r_cycle_cnt != '1) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = '0;
`endif

endmodule

`default_nettype wire
